// File: rtl/aes_round_stage_if.sv
// Handshake bundle between sub_byte (master) and the AES round back-end (slave).
// State arrays are [row][col] 8-bit bytes; FIPS-197 byte n sits at row n%4, column n/4.
interface aes_round_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_state  [4][4];
  logic [7:0] round_key [4][4];
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_state [4][4];
  logic       out_last;

  modport master (
    output in_valid, in_state, round_key, in_last, out_ready,
    input  in_ready, out_valid, out_state, out_last
  );

  modport slave (
    input  in_valid, in_state, round_key, in_last, out_ready,
    output in_ready, out_valid, out_state, out_last
  );
endinterface

// File: rtl/aes_round_stage.sv
// AES round back-end: ShiftRows, MixColumns (bypassed on the final round), AddRoundKey,
// registered behind a valid/ready handshake with an optional one-entry skid buffer.
module aes_round_stage #(
  parameter bit SKID_EN = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  aes_round_stage_if.slave  bus
);

  logic [7:0] sr          [4][4];
  logic [7:0] mc          [4][4];
  logic [7:0] res         [4][4];
  logic [7:0] out_state_q [4][4];
  logic [7:0] skid_state  [4][4];
  logic       out_valid_q;
  logic       out_last_q;
  logic       skid_full;
  logic       skid_last;
  logic       in_ready_c;
  logic       in_xfer;
  logic       out_xfer;
  logic       load_ok;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  always_comb begin
    sr  = '{default: '0};
    mc  = '{default: '0};
    res = '{default: '0};
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        sr[r][c] = bus.in_state[r][2'(c + r)];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      mc[0][c] = xtime(sr[0][c]) ^ mul3(sr[1][c]) ^ sr[2][c]        ^ sr[3][c];
      mc[1][c] = sr[0][c]        ^ xtime(sr[1][c]) ^ mul3(sr[2][c]) ^ sr[3][c];
      mc[2][c] = sr[0][c]        ^ sr[1][c]        ^ xtime(sr[2][c]) ^ mul3(sr[3][c]);
      mc[3][c] = mul3(sr[0][c])  ^ sr[1][c]        ^ sr[2][c]        ^ xtime(sr[3][c]);
    end
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        res[r][c] = (bus.in_last ? sr[r][c] : mc[r][c]) ^ bus.round_key[r][c];
      end
    end
  end

  always_comb begin
    in_ready_c = SKID_EN ? !skid_full : (!out_valid_q || bus.out_ready);
    in_xfer    = bus.in_valid && in_ready_c;
    out_xfer   = out_valid_q && bus.out_ready;
    load_ok    = !out_valid_q || bus.out_ready;
  end

  // A full skid blocks new inputs, so draining it never races an input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q <= '{default: '0};
      skid_state  <= '{default: '0};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      skid_full   <= 1'b0;
      skid_last   <= 1'b0;
    end else if (skid_full) begin
      if (out_xfer) begin
        out_state_q <= skid_state;
        out_last_q  <= skid_last;
        out_valid_q <= 1'b1;
        skid_full   <= 1'b0;
      end
    end else if (in_xfer) begin
      if (load_ok) begin
        out_state_q <= res;
        out_last_q  <= bus.in_last;
        out_valid_q <= 1'b1;
      end else begin
        skid_state <= res;
        skid_last  <= bus.in_last;
        skid_full  <= SKID_EN;
      end
    end else if (out_xfer) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_state = out_state_q;

endmodule

// File: tb/tb_aes_round_stage.sv
// Directed bench for aes_round_stage: FIPS-197 vectors, xtime corners, backpressure,
// streaming against an independent GF(2^8) matrix model, and asynchronous reset.
module tb_aes_round_stage;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  aes_round_stage_if bus ();

  aes_round_stage #(.SKID_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [127:0] R1_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] FR_IN   = 128'he9098972cb31075f3d327d94af2e2cb5;
  localparam logic [127:0] FR_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FR_OUT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ALL80   = {16{8'h80}};
  localparam logic [127:0] ONE80   = {8'h80, 120'h0};
  localparam logic [127:0] ONE80_R = {32'h1b80809b, 96'h0};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_in(input logic [127:0] st, input logic [127:0] key,
                          input logic last, input logic valid);
    for (int n = 0; n < 16; n++) begin
      bus.in_state[n % 4][n / 4]  = st[127 - 8*n -: 8];
      bus.round_key[n % 4][n / 4] = key[127 - 8*n -: 8];
    end
    bus.in_last  = last;
    bus.in_valid = valid;
  endtask

  function automatic logic [127:0] out_word();
    logic [127:0] w;
    w = '0;
    for (int n = 0; n < 16; n++) w[127 - 8*n -: 8] = bus.out_state[n % 4][n / 4];
    return w;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant MixColumns matrix rows are {2,3,1,1} rotated right by the row index.
  function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] key,
                                         input logic last);
    logic [7:0]   coef [4];
    logic [7:0]   s    [4][4];
    logic [7:0]   acc;
    logic [127:0] o;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int n = 0; n < 16; n++) s[n % 4][(n / 4 + 4 - n % 4) % 4] = st[127 - 8*n -: 8];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (last) acc = s[r][c];
        else begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], s[k][c]);
        end
        o[127 - 8*(4*c + r) -: 8] = acc ^ key[127 - 8*(4*c + r) -: 8];
      end
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input string tag, input logic [127:0] st, input logic [127:0] key,
                        input logic last, input logic [127:0] exp);
    drive_in(st, key, last, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, 128'(bus.out_valid), 128'(1'b1));
    check({tag, "_state"}, out_word(), exp);
    check({tag, "_last"}, 128'(bus.out_last), 128'(last));
    tick();
    check({tag, "_drain"}, 128'(bus.out_valid), 128'(1'b0));
  endtask

  logic [127:0] st_i;
  logic [127:0] key_i;
  logic [127:0] w;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    bus.out_ready = 1'b1;
    drive_in('0, '0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(bus.out_valid), 128'(1'b0));
    check("rst_out_last", 128'(bus.out_last), 128'(1'b0));
    check("rst_out_state", out_word(), 128'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 128'(bus.in_ready), 128'(1'b1));

    single("round1", R1_IN, R1_KEY, 1'b0, R1_OUT);
    single("final", FR_IN, FR_KEY, 1'b1, FR_OUT);

    drive_in(R1_IN, '0, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    w = out_word();
    check("xtime_col0", 128'(w[127:96]), 128'(32'h046681e5));
    single("all80", ALL80, '0, 1'b0, ALL80);
    single("one80", ONE80, '0, 1'b0, ONE80_R);

    // Backpressure: A held, B into skid, C refused until the skid drains.
    bus.out_ready = 1'b0;
    drive_in(R1_IN, R1_KEY, 1'b0, 1'b1);
    tick();
    check("bp_ready_after_a", 128'(bus.in_ready), 128'(1'b1));
    drive_in(FR_IN, FR_KEY, 1'b1, 1'b1);
    tick();
    check("bp_ready_after_b", 128'(bus.in_ready), 128'(1'b0));
    check("bp_hold_a", out_word(), R1_OUT);
    drive_in(ALL80, '0, 1'b0, 1'b1);
    tick();
    check("bp_refuse_c", 128'(bus.in_ready), 128'(1'b0));
    check("bp_a_valid", 128'(bus.out_valid), 128'(1'b1));
    check("bp_a_state", out_word(), R1_OUT);
    check("bp_a_last", 128'(bus.out_last), 128'(1'b0));
    bus.out_ready = 1'b1;
    tick();
    check("bp_b_valid", 128'(bus.out_valid), 128'(1'b1));
    check("bp_b_state", out_word(), FR_OUT);
    check("bp_b_last", 128'(bus.out_last), 128'(1'b1));
    tick();
    bus.in_valid = 1'b0;
    check("bp_c_valid", 128'(bus.out_valid), 128'(1'b1));
    check("bp_c_state", out_word(), ALL80);
    check("bp_c_last", 128'(bus.out_last), 128'(1'b0));
    tick();
    check("bp_drain", 128'(bus.out_valid), 128'(1'b0));

    for (int i = 0; i < 8; i++) begin
      st_i  = 128'h0123456789abcdeffedcba9876543210 ^ {16{8'(i * 37 + 5)}};
      key_i = 128'h2b7e151628aed2a6abf7158809cf4f3c + 128'(i * 7919);
      drive_in(st_i, key_i, i[0] & i[1], 1'b1);
      tick();
      check("stream_valid", 128'(bus.out_valid), 128'(1'b1));
      check("stream_state", out_word(), model(st_i, key_i, i[0] & i[1]));
      check("stream_last", 128'(bus.out_last), 128'(i[0] & i[1]));
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_drain", 128'(bus.out_valid), 128'(1'b0));

    bus.out_ready = 1'b0;
    drive_in(FR_IN, FR_KEY, 1'b1, 1'b1);
    tick();
    drive_in(R1_IN, R1_KEY, 1'b0, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("mid_skid_full", 128'(bus.in_ready), 128'(1'b0));
    check("mid_out_last_pre", 128'(bus.out_last), 128'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(bus.out_valid), 128'(1'b0));
    check("mid_rst_state", out_word(), 128'h0);
    check("mid_rst_last", 128'(bus.out_last), 128'(1'b0));
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check("mid_rel_ready", 128'(bus.in_ready), 128'(1'b1));
    tick();
    check("mid_no_stale_1", 128'(bus.out_valid), 128'(1'b0));
    tick();
    check("mid_no_stale_2", 128'(bus.out_valid), 128'(1'b0));
    check("mid_state_zero", out_word(), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
